gecko_writeback_scoreboard: RTL and testbench

- Writeback-side counterpart to the gecko decode operand checks: holds the 32-entry integer register file and the per-register pending-write counters (gecko_reg_status_t).
- Decode reserves rd on issue and reads the counters to find rs1/rs2/rd status.
- Writeback retires results, which decrements the counter and optionally writes the value.
- Register reads have one-cycle latency; a post-reset sequencer zero-fills the file.

---
 rtl/gecko_writeback_scoreboard.sv | 155 +++++++++++++++
 tb/tb_gecko_writeback_scoreboard.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/gecko_writeback_scoreboard.sv
// Writeback-side register file and pending-write scoreboard for the gecko core.
// Decode reserves rd, writeback retires it; a post-reset sequencer zero-fills the file.
module gecko_writeback_scoreboard #(
    parameter int STATUS_WIDTH = 2,
    parameter int REG_COUNT    = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    output logic                              init_done,
    input  logic                              reserve_valid,
    input  logic [4:0]                        reserve_addr,
    output logic                              reserve_ready,
    input  logic                              wb_valid,
    input  logic [4:0]                        wb_addr,
    input  logic [31:0]                       wb_value,
    input  logic                              wb_skip,
    output logic                              wb_ready,
    input  logic [4:0]                        rs1_addr,
    input  logic [4:0]                        rs2_addr,
    output logic [31:0]                       rs1_value,
    output logic [31:0]                       rs2_value,
    output logic [REG_COUNT*STATUS_WIDTH-1:0] status,
    output logic                              error
);

    // Handshake: reserve and writeback are accepted on any edge where
    // valid && ready; ready is high throughout RUN and low during INIT/reset.

    localparam logic [STATUS_WIDTH-1:0] ST_VALID = '0;
    localparam logic [STATUS_WIDTH-1:0] ST_FULL  = '1;
    localparam logic [STATUS_WIDTH-1:0] CNT_ONE  = STATUS_WIDTH'(1);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [4:0]              init_idx_q, init_idx_d;
    logic [STATUS_WIDTH-1:0] cnt_q [REG_COUNT];
    logic [STATUS_WIDTH-1:0] cnt_d [REG_COUNT];
    logic [31:0]             regs_q [REG_COUNT];
    logic                    err_q, err_d;
    logic [31:0]             rs1_q, rs1_d;
    logic [31:0]             rs2_q, rs2_d;

    logic                    run;
    logic                    res_acc, wb_acc, paired;
    logic [STATUS_WIDTH-1:0] res_cnt, wb_cnt;
    logic                    res_inc, res_err, wb_dec, wb_err, wr_en;

    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        case (state_q)
            ST_INIT: begin
                init_idx_d = init_idx_q + 5'd1;
                if (init_idx_q == 5'd31) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    assign run = (state_q == ST_RUN);

    // x0 is never tracked, so requests to it are dropped before the counter logic.
    assign res_acc = reserve_valid && run && (reserve_addr != 5'd0);
    assign wb_acc  = wb_valid && run && (wb_addr != 5'd0);
    assign paired  = res_acc && wb_acc && (reserve_addr == wb_addr);
    assign res_cnt = cnt_q[reserve_addr];
    assign wb_cnt  = cnt_q[wb_addr];

    // A paired reserve+retire nets to zero, so saturation checks do not apply.
    assign res_inc = res_acc && !paired && (res_cnt != ST_FULL);
    assign res_err = res_acc && !paired && (res_cnt == ST_FULL);
    assign wb_dec  = wb_acc && !paired && (wb_cnt != ST_VALID);
    assign wb_err  = wb_acc && !paired && (wb_cnt == ST_VALID);
    assign wr_en   = wb_acc && !wb_skip && (paired || (wb_cnt != ST_VALID));

    always_comb begin
        for (int i = 0; i < REG_COUNT; i++) begin
            cnt_d[i] = cnt_q[i];
            if (res_inc && (reserve_addr == 5'(i))) begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
            if (wb_dec && (wb_addr == 5'(i))) begin
                cnt_d[i] = cnt_q[i] - CNT_ONE;
            end
        end
        err_d = err_q | res_err | wb_err;
    end

    // Reads are write-first: a same-cycle committed retire is forwarded.
    always_comb begin
        rs1_d = '0;
        rs2_d = '0;
        if (run && (rs1_addr != 5'd0)) begin
            rs1_d = (wr_en && (wb_addr == rs1_addr)) ? wb_value : regs_q[rs1_addr];
        end
        if (run && (rs2_addr != 5'd0)) begin
            rs2_d = (wr_en && (wb_addr == rs2_addr)) ? wb_value : regs_q[rs2_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_INIT;
            init_idx_q <= 5'd0;
            err_q      <= 1'b0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            for (int i = 0; i < REG_COUNT; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
            err_q      <= err_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            for (int i = 0; i < REG_COUNT; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // The file itself has no reset; the INIT sequencer clears it instead.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (state_q == ST_INIT) begin
                regs_q[init_idx_q] <= '0;
            end else if (wr_en) begin
                regs_q[wb_addr] <= wb_value;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < REG_COUNT; i++) begin
            status[i*STATUS_WIDTH +: STATUS_WIDTH] = cnt_q[i];
        end
    end

    assign init_done     = run;
    assign reserve_ready = run;
    assign wb_ready      = run;
    assign rs1_value     = rs1_q;
    assign rs2_value     = rs2_q;
    assign error         = err_q;

endmodule

// File: tb/tb_gecko_writeback_scoreboard.sv
// Bench for gecko_writeback_scoreboard: directed vector table, reset/INIT
// sequences, and randomized traffic checked against an array-based model.
module tb_gecko_writeback_scoreboard;

    logic        clk;
    logic        rst;
    logic        init_done;
    logic        reserve_valid;
    logic [4:0]  reserve_addr;
    logic        reserve_ready;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_value;
    logic        wb_skip;
    logic        wb_ready;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_value;
    logic [31:0] rs2_value;
    logic [63:0] status;
    logic        error;

    int n_vec = 0;
    int n_err = 0;

    gecko_writeback_scoreboard dut (
        .clk           (clk),
        .rst           (rst),
        .init_done     (init_done),
        .reserve_valid (reserve_valid),
        .reserve_addr  (reserve_addr),
        .reserve_ready (reserve_ready),
        .wb_valid      (wb_valid),
        .wb_addr       (wb_addr),
        .wb_value      (wb_value),
        .wb_skip       (wb_skip),
        .wb_ready      (wb_ready),
        .rs1_addr      (rs1_addr),
        .rs2_addr      (rs2_addr),
        .rs1_value     (rs1_value),
        .rs2_value     (rs2_value),
        .status        (status),
        .error         (error)
    );

    // Clock and reset-free clock generation; inputs change on negedge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rv;
        logic [4:0]  ra;
        logic        wv;
        logic [4:0]  wa;
        logic [31:0] wval;
        logic        skip;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [4:0]  chk;
        logic [1:0]  exp_stat;
        logic [31:0] exp_r1;
        logic [31:0] exp_r2;
        logic        exp_err;
    } vec_t;

    vec_t tbl[$];

    // Reference model state
    int          m_cnt [32];
    logic [31:0] m_rf  [32];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic rv, input logic [4:0] ra, input logic wv,
                         input logic [4:0] wa, input logic [31:0] wval, input logic skip,
                         input logic [4:0] r1, input logic [4:0] r2);
        reserve_valid = rv;
        reserve_addr  = ra;
        wb_valid      = wv;
        wb_addr       = wa;
        wb_value      = wval;
        wb_skip       = skip;
        rs1_addr      = r1;
        rs2_addr      = r2;
    endtask

    task automatic add(input logic rv, input logic [4:0] ra, input logic wv,
                       input logic [4:0] wa, input logic [31:0] wval, input logic skip,
                       input logic [4:0] r1, input logic [4:0] chk, input logic [1:0] es,
                       input logic [31:0] er1, input logic [31:0] er2, input logic ee);
        vec_t v;
        v.rv = rv; v.ra = ra; v.wv = wv; v.wa = wa; v.wval = wval; v.skip = skip;
        v.r1 = r1; v.r2 = 5'd3; v.chk = chk; v.exp_stat = es;
        v.exp_r1 = er1; v.exp_r2 = er2; v.exp_err = ee;
        tbl.push_back(v);
    endtask

    // Releases reset on the current negedge and checks the zero-fill timing.
    task automatic release_and_check_init(input string tag);
        rst = 1'b1;
        for (int i = 0; i < 32; i++) begin
            check($sformatf("%s init_done low c%0d", tag, i + 1), 64'(init_done), 64'd0);
            if (i == 0) begin
                check($sformatf("%s wb_ready in INIT", tag), 64'(wb_ready), 64'd0);
                check($sformatf("%s reserve_ready in INIT", tag), 64'(reserve_ready), 64'd0);
            end
            if (i == 31) begin
                check($sformatf("%s rs1 during INIT", tag), 64'(rs1_value), 64'd0);
            end
            step();
        end
        check($sformatf("%s init_done high c33", tag), 64'(init_done), 64'd1);
    endtask

    logic [63:0] exp_status;

    initial begin
        rst = 1'b0;
        drive(1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd5, 5'd0);
        @(negedge clk);
        step();
        step();
        check("reset init_done", 64'(init_done), 64'd0);
        check("reset rs1_value", 64'(rs1_value), 64'd0);
        check("reset error", 64'(error), 64'd0);
        check("reset status", status, 64'd0);

        release_and_check_init("boot");
        step();
        check("boot x5 reads 0", 64'(rs1_value), 64'd0);
        check("boot status all 0", status, 64'd0);
        check("boot error", 64'(error), 64'd0);

        //    rv  ra     wv  wa     wval          sk  r1     chk    st    er1           er2           err
        add(1, 5'd3,  0, 5'd0,  32'h0,        0, 5'd3,  5'd3,  2'd1, 32'h0,        32'h0,        0);
        add(0, 5'd0,  1, 5'd3,  32'hDEADBEEF, 0, 5'd3,  5'd3,  2'd0, 32'hDEADBEEF, 32'hDEADBEEF, 0);
        add(0, 5'd0,  0, 5'd0,  32'h0,        0, 5'd3,  5'd3,  2'd0, 32'hDEADBEEF, 32'hDEADBEEF, 0);
        add(1, 5'd9,  0, 5'd0,  32'h0,        0, 5'd9,  5'd9,  2'd1, 32'h0,        32'hDEADBEEF, 0);
        add(1, 5'd9,  0, 5'd0,  32'h0,        0, 5'd9,  5'd9,  2'd2, 32'h0,        32'hDEADBEEF, 0);
        add(0, 5'd0,  1, 5'd9,  32'h12345678, 0, 5'd9,  5'd9,  2'd1, 32'h12345678, 32'hDEADBEEF, 0);
        add(0, 5'd0,  1, 5'd9,  32'hAAAA5555, 1, 5'd9,  5'd9,  2'd0, 32'h12345678, 32'hDEADBEEF, 0);
        add(1, 5'd4,  0, 5'd0,  32'h0,        0, 5'd4,  5'd4,  2'd1, 32'h0,        32'hDEADBEEF, 0);
        add(1, 5'd4,  1, 5'd4,  32'h00000044, 0, 5'd4,  5'd4,  2'd1, 32'h00000044, 32'hDEADBEEF, 0);
        add(1, 5'd0,  1, 5'd0,  32'h0000FFFF, 0, 5'd0,  5'd0,  2'd0, 32'h0,        32'hDEADBEEF, 0);
        add(0, 5'd0,  1, 5'd0,  32'h00000005, 0, 5'd0,  5'd4,  2'd1, 32'h0,        32'hDEADBEEF, 0);
        add(1, 5'd7,  0, 5'd0,  32'h0,        0, 5'd4,  5'd7,  2'd1, 32'h00000044, 32'hDEADBEEF, 0);
        add(1, 5'd7,  0, 5'd0,  32'h0,        0, 5'd4,  5'd7,  2'd2, 32'h00000044, 32'hDEADBEEF, 0);
        add(1, 5'd7,  0, 5'd0,  32'h0,        0, 5'd4,  5'd7,  2'd3, 32'h00000044, 32'hDEADBEEF, 0);
        add(1, 5'd7,  0, 5'd0,  32'h0,        0, 5'd4,  5'd7,  2'd3, 32'h00000044, 32'hDEADBEEF, 1);
        add(0, 5'd0,  1, 5'd12, 32'h00000BAD, 0, 5'd12, 5'd12, 2'd0, 32'h0,        32'hDEADBEEF, 1);
        add(0, 5'd0,  0, 5'd0,  32'h0,        0, 5'd9,  5'd9,  2'd0, 32'h12345678, 32'hDEADBEEF, 1);

        foreach (tbl[k]) begin
            drive(tbl[k].rv, tbl[k].ra, tbl[k].wv, tbl[k].wa, tbl[k].wval, tbl[k].skip,
                  tbl[k].r1, tbl[k].r2);
            step();
            check($sformatf("vec%0d status[%0d]", k, tbl[k].chk),
                  64'(status[tbl[k].chk*2 +: 2]), 64'(tbl[k].exp_stat));
            check($sformatf("vec%0d rs1", k), 64'(rs1_value), 64'(tbl[k].exp_r1));
            check($sformatf("vec%0d rs2", k), 64'(rs2_value), 64'(tbl[k].exp_r2));
            check($sformatf("vec%0d error", k), 64'(error), 64'(tbl[k].exp_err));
        end

        // Mid-run reset with a writeback to x12 held through reset and INIT.
        drive(1'b0, 5'd0, 1'b1, 5'd12, 32'hBAD5BAD5, 1'b0, 5'd12, 5'd3);
        rst = 1'b0;
        step();
        check("midreset error cleared", 64'(error), 64'd0);
        check("midreset init_done", 64'(init_done), 64'd0);
        check("midreset rs1", 64'(rs1_value), 64'd0);
        check("midreset status", status, 64'd0);
        release_and_check_init("rerun");
        drive(1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd12, 5'd3);
        step();
        check("rerun x12 reads 0", 64'(rs1_value), 64'd0);
        check("rerun x3 reads 0", 64'(rs2_value), 64'd0);
        check("rerun status", status, 64'd0);
        check("rerun error", 64'(error), 64'd0);

        // Randomized legal traffic against the model.
        for (int i = 0; i < 32; i++) begin
            m_cnt[i] = 0;
            m_rf[i]  = '0;
        end
        for (int n = 0; n < 300; n++) begin
            logic        rv, wv, sk;
            logic [4:0]  ra, wa, r1, r2;
            logic [31:0] val, e1, e2;
            rv  = 1'($urandom_range(0, 1));
            ra  = 5'($urandom_range(0, 7));
            wv  = 1'($urandom_range(0, 1));
            wa  = 5'($urandom_range(0, 7));
            sk  = ($urandom_range(0, 3) == 0);
            val = $urandom;
            r1  = 5'($urandom_range(0, 7));
            r2  = 5'($urandom_range(0, 7));
            if (rv && ra != 0 && m_cnt[ra] == 3) rv = 1'b0;
            if (wv && wa != 0 && m_cnt[wa] == 0) wv = 1'b0;

            if (rv && ra != 0) m_cnt[ra] = m_cnt[ra] + 1;
            if (wv && wa != 0) begin
                m_cnt[wa] = m_cnt[wa] - 1;
                if (!sk) m_rf[wa] = val;
            end
            e1 = (r1 == 0) ? 32'd0 : m_rf[r1];
            e2 = (r2 == 0) ? 32'd0 : m_rf[r2];
            for (int i = 0; i < 32; i++) exp_status[i*2 +: 2] = 2'(m_cnt[i]);

            drive(rv, ra, wv, wa, val, sk, r1, r2);
            step();
            check($sformatf("rnd%0d status", n), status, exp_status);
            check($sformatf("rnd%0d rs1 x%0d", n, r1), 64'(rs1_value), 64'(e1));
            check($sformatf("rnd%0d rs2 x%0d", n, r2), 64'(rs2_value), 64'(e2));
            check($sformatf("rnd%0d error", n), 64'(error), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
